// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, load/store port and the memory-side signals.
// slave = arbiter view, master = requesters plus memory (environment) view.
interface mem_arbiter_if;
  logic        i_req_valid;
  logic        i_req_ready;
  logic [15:0] i_addr;
  logic        i_rsp_valid;
  logic [15:0] i_rsp_data;

  logic        d_req_valid;
  logic        d_req_ready;
  logic        d_we;
  logic        d_byte_en;
  logic        d_byte_sel;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_rsp_valid;
  logic [15:0] d_rsp_data;

  logic        mem_en;
  logic        mem_we;
  logic        mem_byte_enable;
  logic        mem_byte_select;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
  logic        mem_wait;

  modport slave (
    input  i_req_valid, i_addr,
    input  d_req_valid, d_we, d_byte_en, d_byte_sel, d_addr, d_wdata,
    input  mem_data_out, mem_wait,
    output i_req_ready, i_rsp_valid, i_rsp_data,
    output d_req_ready, d_rsp_valid, d_rsp_data,
    output mem_en, mem_we, mem_byte_enable, mem_byte_select, mem_addr, mem_data_in
  );

  modport master (
    output i_req_valid, i_addr,
    output d_req_valid, d_we, d_byte_en, d_byte_sel, d_addr, d_wdata,
    output mem_data_out, mem_wait,
    input  i_req_ready, i_rsp_valid, i_rsp_data,
    input  d_req_ready, d_rsp_valid, d_rsp_data,
    input  mem_en, mem_we, mem_byte_enable, mem_byte_select, mem_addr, mem_data_in
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter for the single-port data memory, 2-cycle read latency.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of data priority with starvation override.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  logic accept_ok;
  logic fetch_pri;
  logic grant_i;
  logic grant_d;

  assign accept_ok = !rst && !bus.mem_wait;

`ifdef MEM_ARB_RR_EN
  // Pointer set means fetch wins the next contention; it flips only on an accept.
  logic rr_fetch_pri_reg;
  logic rr_fetch_pri_next;

  always_comb begin
    rr_fetch_pri_next = rr_fetch_pri_reg;
    if (grant_i) begin
      rr_fetch_pri_next = 1'b0;
    end else if (grant_d) begin
      rr_fetch_pri_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_fetch_pri_reg <= 1'b1;
    end else begin
      rr_fetch_pri_reg <= rr_fetch_pri_next;
    end
  end

  assign fetch_pri = rr_fetch_pri_reg;
`else
  localparam logic [CNT_W-1:0] STARVE_LIM_C = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  logic [CNT_W-1:0] starve_cnt_reg;
  logic [CNT_W-1:0] starve_cnt_next;

  // A stalled memory freezes the count so the stall does not count against fetch.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!bus.mem_wait) begin
      if (!bus.i_req_valid || grant_i) begin
        starve_cnt_next = '0;
      end else if (starve_cnt_reg != CNT_MAX) begin
        starve_cnt_next = starve_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  assign fetch_pri = (STARVE_LIMIT != 0) && (starve_cnt_reg >= STARVE_LIM_C);
`endif

  assign grant_i = accept_ok && bus.i_req_valid && (!bus.d_req_valid || fetch_pri);
  assign grant_d = accept_ok && bus.d_req_valid && (!bus.i_req_valid || !fetch_pri);

  assign bus.i_req_ready = grant_i;
  assign bus.d_req_ready = grant_d;

  always_comb begin
    bus.mem_en          = 1'b0;
    bus.mem_we          = 1'b0;
    bus.mem_byte_enable = 1'b0;
    bus.mem_byte_select = 1'b0;
    bus.mem_addr        = '0;
    bus.mem_data_in     = '0;
    if (grant_d) begin
      bus.mem_en          = 1'b1;
      bus.mem_we          = bus.d_we;
      bus.mem_byte_enable = bus.d_byte_en;
      bus.mem_byte_select = bus.d_byte_sel;
      bus.mem_addr        = bus.d_addr;
      bus.mem_data_in     = bus.d_wdata;
    end else if (grant_i) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.i_addr;
    end
  end

  // Stage 1 tags the access issued at the accept edge; port 1 = data, 0 = fetch.
  logic s1_valid_reg, s1_valid_next;
  logic s1_port_reg,  s1_port_next;
  logic s1_we_reg,    s1_we_next;

  always_comb begin
    s1_valid_next = grant_i || grant_d;
    s1_port_next  = grant_d;
    s1_we_next    = grant_d && bus.d_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_port_reg  <= 1'b0;
      s1_we_reg    <= 1'b0;
    end else begin
      s1_valid_reg <= s1_valid_next;
      s1_port_reg  <= s1_port_next;
      s1_we_reg    <= s1_we_next;
    end
  end

  // One response register set per port; index 0 = fetch, 1 = data.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    logic        hit;
    logic        valid_reg;
    logic [15:0] data_reg;

    assign hit = s1_valid_reg && (s1_port_reg == 1'(gi));

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_reg <= 1'b0;
        data_reg  <= '0;
      end else begin
        valid_reg <= hit;
        if (hit) begin
          data_reg <= s1_we_reg ? 16'h0000 : bus.mem_data_out;
        end
      end
    end
  end

  assign bus.i_rsp_valid = g_rsp[0].valid_reg;
  assign bus.i_rsp_data  = g_rsp[0].data_reg;
  assign bus.d_rsp_valid = g_rsp[1].valid_reg;
  assign bus.d_rsp_data  = g_rsp[1].data_reg;

endmodule
